// File: rtl/anc_calibration_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// anc_pkg : shared state, output-mode types and tick constants for the
//           ANC calibration sequencer.  Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package anc_pkg;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    MUTE_SETTLE  = 3'd1,
    OFFSET       = 3'd2,
    ARM          = 3'd3,
    WAIT_IMPULSE = 3'd4,
    RUN          = 3'd5,
    FAULT        = 3'd6
  } cal_state_t;

  typedef enum logic [1:0] {
    MODE_MUTE   = 2'd0,
    MODE_UNCONV = 2'd1,
    MODE_CONV   = 2'd2
  } out_mode_t;

  localparam int unsigned TICK_RATE_HZ = 24000;
  localparam int          TICK_W       = 16;

endpackage

`default_nettype wire

// File: rtl/anc_calibration_sequencer_tick_timer.sv
// ---------------------------------------------------------------------------
// tick_timer : 16-bit audio-strobe counter with clear and a runtime
//              threshold done flag.  Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tick_timer
  import anc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_tick,
  input  logic [TICK_W-1:0] i_threshold,
  output logic              o_done
);

  logic [TICK_W-1:0] count_q;
  logic [TICK_W-1:0] count_d;

  // Saturates so an idle state parked for a long time never wraps to zero.
  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (i_tick && (count_q != {TICK_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_done = (count_q >= i_threshold);

endmodule

`default_nettype wire

// File: rtl/anc_calibration_sequencer.sv
// ---------------------------------------------------------------------------
// anc_calibration_sequencer : mute, offset capture, impulse recording with
//                             timeout/retry, then convolved output.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module anc_calibration_sequencer
  import anc_pkg::*;
#(
  parameter int unsigned SETTLE_TICKS          = 2400,
  parameter int unsigned OFFSET_TICKS          = 4800,
  parameter int unsigned IMPULSE_TIMEOUT_TICKS = 48000,
  parameter int unsigned MAX_RETRIES           = 2
) (
  input  logic       audio_clk,
  input  logic       rst_in,
  input  logic       audio_trigger,
  input  logic       start_in,
  input  logic       abort_in,
  input  logic       impulse_recorded_in,
  output logic       offset_trigger_out,
  output logic       record_trigger_out,
  output logic       mute_system_out,
  output logic [1:0] mode_out,
  output logic       busy_out,
  output logic       error_out,
  output logic [2:0] state_out,
  output logic [1:0] attempt_out
);

  localparam logic [TICK_W-1:0] c_SETTLE  = TICK_W'(SETTLE_TICKS);
  localparam logic [TICK_W-1:0] c_OFFSET  = TICK_W'(OFFSET_TICKS);
  localparam logic [TICK_W-1:0] c_TIMEOUT = TICK_W'(IMPULSE_TIMEOUT_TICKS);

  cal_state_t        state_q, state_d;
  logic [1:0]        attempt_q, attempt_d;
  logic              start_prev_q, imp_prev_q;
  logic              offset_q, offset_d;
  logic              record_q, record_d;
  logic              mute_q, mute_d;
  out_mode_t         mode_q, mode_d;
  logic              busy_q, busy_d;
  logic              error_q, error_d;
  logic [TICK_W-1:0] threshold;
  logic              timer_done;
  logic              start_rise, imp_rise, imp_fall;

  assign start_rise = start_in & ~start_prev_q;
  assign imp_rise   = impulse_recorded_in & ~imp_prev_q;
  assign imp_fall   = ~impulse_recorded_in & imp_prev_q;

  always_comb begin
    threshold = c_TIMEOUT;
    case (state_q)
      MUTE_SETTLE: threshold = c_SETTLE;
      OFFSET:      threshold = c_OFFSET;
      default:     threshold = c_TIMEOUT;
    endcase
  end

  // Clearing on any state change gives every timed state a fresh count.
  tick_timer u_tick_timer (
    .clk         (audio_clk),
    .rst         (rst_in),
    .i_clear     (state_d != state_q),
    .i_tick      (audio_trigger),
    .i_threshold (threshold),
    .o_done      (timer_done)
  );

  always_comb begin
    state_d   = state_q;
    attempt_d = attempt_q;
    if (abort_in) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, RUN, FAULT: begin
          if (start_rise) begin
            state_d   = MUTE_SETTLE;
            attempt_d = 2'd0;
          end else if ((state_q == RUN) && imp_fall) begin
            state_d = MUTE_SETTLE;
          end
        end
        MUTE_SETTLE:  if (timer_done) state_d = OFFSET;
        OFFSET:       if (timer_done) state_d = ARM;
        ARM: begin
          state_d   = WAIT_IMPULSE;
          attempt_d = (attempt_q == 2'd3) ? 2'd3 : attempt_q + 2'd1;
        end
        // Completion is tested first so it beats a coincident timeout.
        WAIT_IMPULSE: begin
          if (imp_rise) begin
            state_d = RUN;
          end else if (timer_done) begin
            state_d = (32'(attempt_q) <= MAX_RETRIES) ? ARM : FAULT;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs decode the next state so the registered copies line up with state_q.
  always_comb begin
    offset_d = (state_d == OFFSET);
    record_d = (state_d == ARM);
    mute_d   = 1'b1;
    mode_d   = MODE_MUTE;
    busy_d   = 1'b0;
    error_d  = 1'b0;
    case (state_d)
      MUTE_SETTLE, OFFSET, ARM, WAIT_IMPULSE: busy_d = 1'b1;
      RUN: begin
        mute_d = 1'b0;
        mode_d = MODE_CONV;
      end
      FAULT: begin
        mute_d  = 1'b0;
        mode_d  = MODE_UNCONV;
        error_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge audio_clk) begin
    if (rst_in) begin
      state_q      <= IDLE;
      attempt_q    <= 2'd0;
      start_prev_q <= 1'b0;
      imp_prev_q   <= 1'b0;
      offset_q     <= 1'b0;
      record_q     <= 1'b0;
      mute_q       <= 1'b1;
      mode_q       <= MODE_MUTE;
      busy_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      attempt_q    <= attempt_d;
      start_prev_q <= start_in;
      imp_prev_q   <= impulse_recorded_in;
      offset_q     <= offset_d;
      record_q     <= record_d;
      mute_q       <= mute_d;
      mode_q       <= mode_d;
      busy_q       <= busy_d;
      error_q      <= error_d;
    end
  end

  assign offset_trigger_out = offset_q;
  assign record_trigger_out = record_q;
  assign mute_system_out    = mute_q;
  assign mode_out           = mode_q;
  assign busy_out           = busy_q;
  assign error_out          = error_q;
  assign state_out          = state_q;
  assign attempt_out        = attempt_q;

endmodule

`default_nettype wire

// File: tb/tb_anc_calibration_sequencer.sv
// ---------------------------------------------------------------------------
// tb_anc_calibration_sequencer : directed scenarios with a per-cycle
//                                behavioural reference.  Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_anc_calibration_sequencer;

  localparam int S  = 4;
  localparam int O  = 3;
  localparam int T  = 10;
  localparam int MR = 2;

  logic       audio_clk = 1'b0;
  logic       rst_in, audio_trigger, start_in, abort_in, impulse_recorded_in;
  logic       offset_trigger_out, record_trigger_out, mute_system_out;
  logic       busy_out, error_out;
  logic [1:0] mode_out, attempt_out;
  logic [2:0] state_out;

  int checks = 0;
  int errors = 0;

  anc_calibration_sequencer #(
    .SETTLE_TICKS(S), .OFFSET_TICKS(O), .IMPULSE_TIMEOUT_TICKS(T), .MAX_RETRIES(MR)
  ) dut (
    .audio_clk(audio_clk), .rst_in(rst_in), .audio_trigger(audio_trigger),
    .start_in(start_in), .abort_in(abort_in), .impulse_recorded_in(impulse_recorded_in),
    .offset_trigger_out(offset_trigger_out), .record_trigger_out(record_trigger_out),
    .mute_system_out(mute_system_out), .mode_out(mode_out), .busy_out(busy_out),
    .error_out(error_out), .state_out(state_out), .attempt_out(attempt_out)
  );

  always #5 audio_clk = ~audio_clk;

  // One-cycle strobe every 8 clocks, changed mid-cycle away from both edges.
  initial begin
    audio_trigger = 1'b0;
    forever begin
      repeat (7) @(posedge audio_clk);
      #3 audio_trigger = 1'b1;
      @(posedge audio_clk);
      #3 audio_trigger = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Reference: the phase the sequencer should occupy, how many strobes it has
  // spent there, and how many recording attempts have been made.
  int m_phase, m_strobes, m_tries;
  bit m_start_d, m_imp_d, m_valid = 0;

  always @(posedge audio_clk) begin
    int  nxt, limit;
    bit  go, imp_up, imp_down;
    if (rst_in) begin
      m_phase = 0; m_strobes = 0; m_tries = 0;
      m_start_d = 0; m_imp_d = 0; m_valid = 1;
    end else begin
      go       = start_in && !m_start_d;
      imp_up   = impulse_recorded_in && !m_imp_d;
      imp_down = !impulse_recorded_in && m_imp_d;
      limit    = (m_phase == 1) ? S : (m_phase == 2) ? O : T;
      nxt      = m_phase;
      if (abort_in) nxt = 0;
      else if ((m_phase == 0 || m_phase == 5 || m_phase == 6) && go) begin
        nxt = 1; m_tries = 0;
      end else if (m_phase == 5 && imp_down) nxt = 1;
      else if (m_phase == 3) begin
        nxt = 4; m_tries = (m_tries < 3) ? m_tries + 1 : 3;
      end else if (m_phase == 4 && imp_up) nxt = 5;
      else if ((m_phase >= 1 && m_phase <= 4) && m_phase != 3 && m_strobes >= limit)
        nxt = (m_phase == 4) ? ((m_tries <= MR) ? 3 : 6) : m_phase + 1;
      if (nxt != m_phase) m_strobes = 0;
      else if (audio_trigger) m_strobes = m_strobes + 1;
      m_phase   = nxt;
      m_start_d = start_in;
      m_imp_d   = impulse_recorded_in;
    end
  end

  function automatic logic [11:0] expect_vec(int p, int a);
    logic [1:0] md;
    md = (p == 5) ? 2'd2 : (p == 6) ? 2'd1 : 2'd0;
    return {3'(p), 2'(a), (p <= 4), md, (p == 2), (p == 3),
            (p >= 1 && p <= 4), (p == 6)};
  endfunction

  int rec_cnt = 0, off_cnt = 0, off_last = -1, wait_cnt = 0, prev_state = 0;
  bit rec_prev = 0, off_prev = 0;
  int seq[$];
  int waits[$];

  initial begin
    logic [11:0] act, ex;
    forever begin
      @(posedge audio_clk); #4;
      if (m_valid) begin
        act = {state_out, attempt_out, mute_system_out, mode_out, offset_trigger_out,
               record_trigger_out, busy_out, error_out};
        ex  = expect_vec(m_phase, m_tries);
        checks++;
        if (act !== ex) begin
          errors++;
          $display("FAIL cycle_model t=%0t actual=%b expected=%b", $time, act, ex);
        end
        if (record_trigger_out === 1'b1) begin
          rec_cnt++;
          checks++;
          if (rec_prev) begin
            errors++;
            $display("FAIL record_width t=%0t actual=2+ cycles expected=1", $time);
          end
        end
        if (offset_trigger_out && !off_prev) off_cnt = 0;
        if (offset_trigger_out && audio_trigger) off_cnt++;
        if (!offset_trigger_out && off_prev) off_last = off_cnt;
        if (state_out == 3'd4 && prev_state != 4) wait_cnt = 0;
        if (state_out == 3'd4 && audio_trigger) wait_cnt++;
        if (state_out != 3'd4 && prev_state == 4) waits.push_back(wait_cnt);
        if (int'(state_out) != prev_state) seq.push_back(int'(state_out));
        rec_prev   = record_trigger_out;
        off_prev   = offset_trigger_out;
        prev_state = int'(state_out);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic wait_state(input int s, input int budget, input string nm);
    int k = 0;
    while (int'(state_out) != s && k < budget) begin
      @(negedge audio_clk);
      k++;
    end
    chk(nm, int'(state_out), s);
  endtask

  // Raise the impulse on the cycle after the n-th strobe spent in WAIT.
  task automatic impulse_after(input int n);
    int seen = 0;
    int k = 0;
    while (k < 400) begin
      if (audio_trigger && state_out == 3'd4) seen++;
      if (seen >= n) break;
      @(negedge audio_clk);
      k++;
    end
    chk("impulse_strobes", seen, n);
    @(negedge audio_clk);
    impulse_recorded_in = 1'b1;
    @(negedge audio_clk);
  endtask

  task automatic restart;
    start_in = 1'b0;
    @(negedge audio_clk);
    start_in = 1'b1;
    @(negedge audio_clk);
  endtask

  task automatic check_fault_run(input string nm);
    wait_state(6, 2000, {nm, "_reach_fault"});
    chk({nm, "_records"}, rec_cnt, 3);
    chk({nm, "_waits"}, waits.size(), 3);
    foreach (waits[i]) chk({nm, "_wait_len"}, waits[i], T);
    chk({nm, "_error"}, error_out, 1);
    chk({nm, "_mode"}, mode_out, 1);
    chk({nm, "_attempt"}, attempt_out, 3);
  endtask

  initial begin
    rst_in = 1'b1; start_in = 1'b0; abort_in = 1'b0; impulse_recorded_in = 1'b0;
    repeat (3) @(negedge audio_clk);
    chk("rst_state", state_out, 0);
    chk("rst_mute", mute_system_out, 1);
    chk("rst_mode", mode_out, 0);
    chk("rst_attempt", attempt_out, 0);
    rst_in = 1'b0;
    repeat (2) @(negedge audio_clk);

    // Nominal calibration
    seq.delete(); rec_cnt = 0;
    start_in = 1'b1;
    @(negedge audio_clk);
    chk("start_to_settle", state_out, 1);
    wait_state(4, 500, "nominal_reach_wait");
    impulse_after(5);
    chk("nominal_state", state_out, 5);
    chk("nominal_mode", mode_out, 2);
    chk("nominal_mute", mute_system_out, 0);
    chk("nominal_attempt", attempt_out, 1);
    chk("nominal_records", rec_cnt, 1);
    chk("nominal_offset_ticks", off_last, O);
    chk("nominal_seq_len", seq.size(), 5);
    foreach (seq[i]) chk("nominal_seq", seq[i], i + 1);

    // Recalibrate from RUN with the impulse level already high: never completes
    restart();
    chk("recal_state", state_out, 1);
    chk("recal_attempt", attempt_out, 0);
    rec_cnt = 0; waits.delete();
    check_fault_run("prehigh");

    // Impulse held low throughout: timeout, two retries, FAULT
    impulse_recorded_in = 1'b0;
    start_in = 1'b0;
    @(negedge audio_clk);
    chk("fault_holds", state_out, 6);
    start_in = 1'b1;
    @(negedge audio_clk);
    chk("fault_restart_attempt", attempt_out, 0);
    rec_cnt = 0; waits.delete();
    check_fault_run("low");

    // Abort during OFFSET
    restart();
    wait_state(2, 500, "abort_reach_offset");
    abort_in = 1'b1;
    @(negedge audio_clk);
    abort_in = 1'b0;
    chk("abort_state", state_out, 0);
    chk("abort_offset", offset_trigger_out, 0);
    chk("abort_mute", mute_system_out, 1);
    chk("abort_mode", mode_out, 0);
    rec_cnt = 0;
    repeat (200) @(negedge audio_clk);
    chk("abort_no_record", rec_cnt, 0);

    // Start rise together with abort; held start does not retrigger
    start_in = 1'b0;
    @(negedge audio_clk);
    start_in = 1'b1; abort_in = 1'b1;
    @(negedge audio_clk);
    abort_in = 1'b0;
    chk("start_abort_state", state_out, 0);
    repeat (3) @(negedge audio_clk);
    chk("held_start_idle", state_out, 0);

    // Impulse rise on the timeout cycle: completion wins
    rec_cnt = 0;
    restart();
    wait_state(4, 500, "simul_reach_wait");
    impulse_after(T);
    chk("simul_state", state_out, 5);
    chk("simul_records", rec_cnt, 1);

    // Impulse invalidated in RUN
    impulse_recorded_in = 1'b0;
    @(negedge audio_clk);
    chk("imp_fall_state", state_out, 1);

    // Reset while waiting for the impulse
    start_in = 1'b0;
    wait_state(4, 500, "rst_reach_wait");
    rst_in = 1'b1;
    @(negedge audio_clk);
    chk("midrst_state", state_out, 0);
    chk("midrst_mute", mute_system_out, 1);
    chk("midrst_attempt", attempt_out, 0);
    chk("midrst_busy", busy_out, 0);
    chk("midrst_record", record_trigger_out, 0);
    rst_in = 1'b0;
    repeat (20) @(negedge audio_clk);
    chk("post_rst_idle", state_out, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
